comp_share_coeff_encoder: RTL and testbench
===========================================

// Module: comp_share_coeff_encoder
// PURPOSE
//  Encoder side of the computation-sharing multiplier.
//  - Takes one POLY_WIDTH-bit FIR coefficient and decomposes it into a stream of commands, one per
//    non-zero 4-bit window: {odd-multiple select, left shift}.
//  - The datapath rebuilds coeff*x from the precomputed odd multiples x1..x15 as sum(x(2*sel+1) << shift).
//  - Sits between coefficient storage and the shift-add datapath; valid/ready on both sides.
// PARAMETERS
//  POLY_WIDTH  17  coefficient width; NWIN = ceil(POLY_WIDTH/4) windows
//  SHIFT_W     5   shift field width, >= clog2(POLY_WIDTH)
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-low; all state cleared while low
//  coeff_vld  in   1           coeff valid
//  coeff_rdy  out  1           encoder ready for a coefficient
//  coeff      in   POLY_WIDTH  coefficient
//  cmd_vld    out  1           command valid
//  cmd_rdy    in   1           consumer ready
//  cmd_sel    out  3           odd multiple index: multiple = 2*sel+1 (0->x1 .. 7->x15)
//  cmd_shift  out  SHIFT_W     left shift applied to the selected multiple
//  cmd_zero   out  1           coefficient is zero; sel/shift are 0
//  cmd_neg    out  1           subtract this term (signed build only, else 0)
//  cmd_last   out  1           final command of the current coefficient
// BEHAVIOUR
//  Reset values: all outputs 0 except coeff_rdy; state IDLE.
//  coeff_rdy = (state==IDLE), combinational from the state register; it is 0 while reset is low.
//  FSM states:
//  - IDLE: coeff_vld&coeff_rdy latches the magnitude and nz_mask[w] = (window w != 0) -> SCAN.
//  - SCAN: load the command registers from the lowest set bit of nz_mask, clear that bit -> EMIT.
//    An empty mask loads cmd_zero=1, cmd_last=1.
//  - EMIT: cmd_vld=1, all cmd_* held stable until cmd_rdy.
//    - On handshake with cmd_last=0: load the next command on the same edge and stay in EMIT
//      (one command per cycle, no bubbles).
//    - On handshake with cmd_last=1: -> IDLE.
//  Latency: accept at edge N, first cmd_vld at edge N+2. Coefficient throughput: 2 + #commands cycles.
//  Window encode (nibble n != 0, window w):
//  - k = trailing zeros of n
//  - sel = ((n>>k)-1)>>1
//  - shift = 4*w + k
//  - The top window is partial (POLY_WIDTH%4 bits) and is zero-extended.
//  cmd_last = 1 when no bits remain set in nz_mask after the current load.
//  Windows are emitted in ascending w; zero windows produce no command.
//  cmd_vld never drops without a handshake; cmd_rdy with cmd_vld=0 is ignored.
//  coeff_vld outside IDLE is ignored; the source must hold it.
//  Reset low mid-operation: immediate return to IDLE, cmd_vld=0, the partial command stream is discarded.
// CONFIGURATION
//  COMP_SHARE_ENC_SIGNED_EN defined:
//  - coeff is two's complement; the encoder encodes |coeff|.
//  - Every command of a negative coefficient carries cmd_neg=1.
//  - -2^(POLY_WIDTH-1) has magnitude 2^(POLY_WIDTH-1), which fits unsigned: single cmd sel=0,
//    shift=POLY_WIDTH-1.
//  Not defined: coeff is unsigned; cmd_neg is tied 0 and no negation logic exists.
// STRUCTURE
//  Package comp_share_pkg:
//  - state enum {IDLE,SCAN,EMIT}
//  - SEL_W=3
//  - function nwin(POLY_WIDTH)
//  - packed cmd struct {sel,shift,zero,neg,last}; shared with the shift-add datapath.
//  Sub-module comp_share_nibble_enc: combinational 4-bit nibble -> {sel, k}, one instance on the
//  window picked by the nz_mask priority encoder.
// TESTING
//  1. coeff=0x00003 -> single cmd sel=1 shift=0 last=1; coeff_rdy back to 1 one cycle after the handshake.
//  2. coeff=0x10F05 -> three cmds, no gap between them:
//     (sel=2,shift=0) (sel=7,shift=8) (sel=0,shift=16,last=1).
//  3. coeff=0x000C0 -> cmd sel=1 shift=6 last=1; coeff=0 -> cmd_zero=1 last=1.
//  4. Hold cmd_rdy=0 for 5 cycles during test 2 -> cmd_* stable; no command lost or duplicated.
//     coeff_rdy stays 0 throughout.
//  5. SIGNED_EN, coeff=0x1FFFD (-3) -> sel=1 shift=0 neg=1 last=1.
//     SIGNED_EN, coeff=0x10000 -> sel=0 shift=16 neg=1.
//  6. Pulse reset low during the 2nd command of test 2 -> cmd_vld=0 immediately, coeff_rdy=1 after release.
//     A following coeff=0x00003 encodes correctly.

Source files
------------

// File: rtl/comp_share_coeff_encoder_pkg.sv
// Shared types for the computation-sharing multiplier (encoder and shift-add datapath).
package comp_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Odd-multiple index width: 2*sel+1 covers x1..x15.
    localparam int SEL_W = 3;

    // Shift field carried in the shared command word.
    localparam int CMD_SHIFT_W = 5;

    // Number of 4-bit windows covering a coefficient (top window may be partial).
    function automatic int nwin(input int poly_width);
        return (poly_width + 3) / 4;
    endfunction

    // One shift-add command.
    typedef struct packed {
        logic [SEL_W-1:0]       sel;
        logic [CMD_SHIFT_W-1:0] shift;
        logic                   zero;
        logic                   neg;
        logic                   last;
    } cmd_t;

endpackage

// File: rtl/comp_share_coeff_encoder_nibble_enc.sv
// Combinational encode of one non-zero nibble into {odd-multiple select, trailing-zero count}.
// The nibble equals (2*sel+1) << k. A zero nibble gives don't-care outputs.
module comp_share_nibble_enc
    import comp_share_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEL_W-1:0] sel,
    output logic [1:0]       k
);

    // Trailing zeros, then drop the odd part's low bit (always 1) to form the select.
    always_comb begin
        if (nib[0])      k = 2'd0;
        else if (nib[1]) k = 2'd1;
        else if (nib[2]) k = 2'd2;
        else             k = 2'd3;
        sel = SEL_W'(nib >> ({1'b0, k} + 3'd1));
    end

endmodule

// File: rtl/comp_share_coeff_encoder.sv
// Coefficient encoder: splits a coefficient into one {sel, shift} command per non-zero
// 4-bit window, lowest window first, for the shift-add datapath.
// Optional macro COMP_SHARE_ENC_SIGNED_EN: two's-complement coefficients, magnitude encoded
// and every command of a negative coefficient flagged with cmd_neg.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// A producer holds valid and its payload stable until that edge; ready may change freely
// and is ignored while valid is low.
module comp_share_coeff_encoder
    import comp_share_pkg::*;
#(
    parameter int POLY_WIDTH = 17,
    parameter int SHIFT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coeff_vld,
    output logic                  coeff_rdy,
    input  logic [POLY_WIDTH-1:0] coeff,
    output logic                  cmd_vld,
    input  logic                  cmd_rdy,
    output logic [SEL_W-1:0]      cmd_sel,
    output logic [SHIFT_W-1:0]    cmd_shift,
    output logic                  cmd_zero,
    output logic                  cmd_neg,
    output logic                  cmd_last,
    output state_t                dbg_state
);

    localparam int NWIN  = nwin(POLY_WIDTH);
    localparam int PAD_W = 4 * NWIN;
    localparam int WIDX  = (NWIN > 1) ? $clog2(NWIN) : 1;

    state_t             state;
    logic [PAD_W-1:0]   mag_q;
    logic [NWIN-1:0]    nz_mask;
    cmd_t               cmd_q;
    logic               vld_q;

    logic [PAD_W-1:0]   mag_in;
    logic [NWIN-1:0]    mask_in;
    logic               neg_in;

    logic [WIDX-1:0]    win_idx;
    logic [NWIN-1:0]    win_onehot;
    logic [3:0]         win_nib;
    logic [SEL_W-1:0]   nib_sel;
    logic [1:0]         nib_k;
    cmd_t               cmd_next;

`ifdef COMP_SHARE_ENC_SIGNED_EN
    logic               neg_q;

    // Magnitude of a two's-complement coefficient; the most negative value wraps to
    // 2^(POLY_WIDTH-1), which is still correct read as unsigned.
    always_comb begin
        neg_in = coeff[POLY_WIDTH-1];
        mag_in = PAD_W'(neg_in ? (~coeff + 1'b1) : coeff);
    end
`else
    // Unsigned build: coefficient is already the magnitude.
    always_comb begin
        neg_in = 1'b0;
        mag_in = PAD_W'(coeff);
    end
`endif

    // Non-zero flag per window of the incoming magnitude.
    always_comb begin
        mask_in = '0;
        for (int i = 0; i < NWIN; i++) begin
            mask_in[i] = |mag_in[4*i +: 4];
        end
    end

    // Priority encoder: lowest set bit of nz_mask picks the window to emit next.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = NWIN - 1; i >= 0; i--) begin
            if (nz_mask[i]) begin
                win_idx    = WIDX'(i);
                win_onehot = NWIN'(1) << i;
            end
        end
        win_nib = mag_q[{win_idx, 2'b00} +: 4];
    end

    comp_share_nibble_enc u_nibble_enc (
        .nib (win_nib),
        .sel (nib_sel),
        .k   (nib_k)
    );

    // Next command built from the selected window; an empty mask means a zero coefficient.
    always_comb begin
        cmd_next = '0;
        if (nz_mask == '0) begin
            cmd_next.zero = 1'b1;
            cmd_next.last = 1'b1;
        end else begin
            cmd_next.sel   = nib_sel;
            cmd_next.shift = CMD_SHIFT_W'({win_idx, 2'b00}) + CMD_SHIFT_W'(nib_k);
            cmd_next.last  = ((nz_mask & ~win_onehot) == '0);
`ifdef COMP_SHARE_ENC_SIGNED_EN
            cmd_next.neg   = neg_q;
`endif
        end
    end

    // Control FSM with registered command outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mag_q   <= '0;
            nz_mask <= '0;
            cmd_q   <= '0;
            vld_q   <= 1'b0;
`ifdef COMP_SHARE_ENC_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (coeff_vld) begin
                        mag_q   <= mag_in;
                        nz_mask <= mask_in;
`ifdef COMP_SHARE_ENC_SIGNED_EN
                        neg_q   <= neg_in;
`endif
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    cmd_q   <= cmd_next;
                    nz_mask <= nz_mask & ~win_onehot;
                    vld_q   <= 1'b1;
                    state   <= EMIT;
                end
                EMIT: begin
                    if (cmd_rdy) begin
                        if (cmd_q.last) begin
                            cmd_q <= '0;
                            vld_q <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cmd_q   <= cmd_next;
                            nz_mask <= nz_mask & ~win_onehot;
                        end
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // neg_in only matters in the signed build; keep it referenced in both.
    logic unused_neg;
    assign unused_neg = neg_in;

    assign coeff_rdy = (state == IDLE) && reset;
    assign cmd_vld   = vld_q;
    assign cmd_sel   = cmd_q.sel;
    assign cmd_shift = SHIFT_W'(cmd_q.shift);
    assign cmd_zero  = cmd_q.zero;
    assign cmd_neg   = cmd_q.neg;
    assign cmd_last  = cmd_q.last;
    assign dbg_state = state;

endmodule

// File: tb/tb_comp_share_coeff_encoder.sv
// Directed bench for comp_share_coeff_encoder: inputs driven and outputs sampled on the
// falling edge, commands consumed back to back so any bubble is caught.
module tb_comp_share_coeff_encoder;
    import comp_share_pkg::*;

    localparam int PW = 17;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          coeff_vld = 1'b0;
    logic          coeff_rdy;
    logic [PW-1:0] coeff = '0;
    logic          cmd_vld;
    logic          cmd_rdy = 1'b0;
    logic [2:0]    cmd_sel;
    logic [SW-1:0] cmd_shift;
    logic          cmd_zero;
    logic          cmd_neg;
    logic          cmd_last;
    state_t        dbg_state;

    int vectors = 0;
    int miscompares = 0;

    comp_share_coeff_encoder #(.POLY_WIDTH(PW), .SHIFT_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .coeff_vld (coeff_vld),
        .coeff_rdy (coeff_rdy),
        .coeff     (coeff),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_sel   (cmd_sel),
        .cmd_shift (cmd_shift),
        .cmd_zero  (cmd_zero),
        .cmd_neg   (cmd_neg),
        .cmd_last  (cmd_last),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with coeff_rdy expected high; returns at the falling
    // edge where the first command should be visible.
    task automatic accept(input string tag, input logic [PW-1:0] c);
        chk({tag, ".coeff_rdy"}, 32'(coeff_rdy), 32'd1);
        coeff_vld = 1'b1;
        coeff = c;
        @(posedge clk);
        @(negedge clk);
        coeff_vld = 1'b0;
        coeff = '0;
        chk({tag, ".scan_vld"}, 32'(cmd_vld), 32'd0);
        chk({tag, ".scan_rdy"}, 32'(coeff_rdy), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks the command visible now, then consumes it (cmd_rdy must be high).
    task automatic get_cmd(input string tag, input int sel, input int shift,
                           input bit zero, input bit neg, input bit last);
        chk({tag, ".vld"},   32'(cmd_vld),   32'd1);
        chk({tag, ".sel"},   32'(cmd_sel),   32'(sel));
        chk({tag, ".shift"}, 32'(cmd_shift), 32'(shift));
        chk({tag, ".zero"},  32'(cmd_zero),  32'(zero));
        chk({tag, ".neg"},   32'(cmd_neg),   32'(neg));
        chk({tag, ".last"},  32'(cmd_last),  32'(last));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".idle_vld"}, 32'(cmd_vld), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(coeff_rdy), 32'd1);
        chk({tag, ".idle_st"},  32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("rst.coeff_rdy", 32'(coeff_rdy), 32'd0);
        chk("rst.cmd_vld",   32'(cmd_vld),   32'd0);
        chk("rst.cmd_fields", {27'd0, cmd_sel, cmd_zero, cmd_neg},
            32'd0);
        chk("rst.cmd_shift_last", {26'd0, cmd_shift, cmd_last}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("rst");
        cmd_rdy = 1'b1;

        // 1: single command, ready again right after the handshake
        accept("t1", 17'h00003);
        get_cmd("t1.c0", 1, 0, 1'b0, 1'b0, 1'b1);
        chk_idle("t1");

        // 2: three commands, no gap
        accept("t2", 17'h10F05);
        get_cmd("t2.c0", 2, 0,  1'b0, 1'b0, 1'b0);
        get_cmd("t2.c1", 7, 8,  1'b0, 1'b0, 1'b0);
        get_cmd("t2.c2", 0, 16, 1'b0, 1'b0, 1'b1);
        chk_idle("t2");

        // 3: shifted nibble, then zero coefficient
        accept("t3a", 17'h000C0);
        get_cmd("t3a.c0", 1, 6, 1'b0, 1'b0, 1'b1);
        chk_idle("t3a");
        accept("t3b", 17'h00000);
        get_cmd("t3b.c0", 0, 0, 1'b1, 1'b0, 1'b1);
        chk_idle("t3b");

        // 4: back-pressure on the second command of test 2
        accept("t4", 17'h10F05);
        get_cmd("t4.c0", 2, 0, 1'b0, 1'b0, 1'b0);
        cmd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4.hold_vld",   32'(cmd_vld),   32'd1);
            chk("t4.hold_sel",   32'(cmd_sel),   32'd7);
            chk("t4.hold_shift", 32'(cmd_shift), 32'd8);
            chk("t4.hold_last",  32'(cmd_last),  32'd0);
            chk("t4.hold_rdy",   32'(coeff_rdy), 32'd0);
        end
        cmd_rdy = 1'b1;
        get_cmd("t4.c1", 7, 8,  1'b0, 1'b0, 1'b0);
        get_cmd("t4.c2", 0, 16, 1'b0, 1'b0, 1'b1);
        chk_idle("t4");

`ifdef COMP_SHARE_ENC_SIGNED_EN
        // 5: signed magnitudes
        accept("t5a", 17'h1FFFD);
        get_cmd("t5a.c0", 1, 0, 1'b0, 1'b1, 1'b1);
        chk_idle("t5a");
        accept("t5b", 17'h10000);
        get_cmd("t5b.c0", 0, 16, 1'b0, 1'b1, 1'b1);
        chk_idle("t5b");
`endif

        // 6: reset during the second command discards the stream
        accept("t6", 17'h10F05);
        get_cmd("t6.c0", 2, 0, 1'b0, 1'b0, 1'b0);
        chk("t6.pre_vld", 32'(cmd_vld), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6.rst_vld", 32'(cmd_vld), 32'd0);
        chk("t6.rst_rdy", 32'(coeff_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_idle("t6.rel");
        @(negedge clk);
        chk_idle("t6.after");
        accept("t6b", 17'h00003);
        get_cmd("t6b.c0", 1, 0, 1'b0, 1'b0, 1'b1);
        chk_idle("t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
